tm_frame_serializer: RTL
========================

Name: tm_frame_serializer

Overview:
- Parametrised telemetry frame serializer, successor to the fixed 9-bit load/shift PISO.
- Accepts parallel words over a valid/ready handshake into a one-word holding buffer.
- Emits frames on a one-bit serial line, paced by a bit strobe: a sync word, then WORDS_PER_FRAME data words.
- Fills missing words with a fill pattern and flags underrun. Sits in front of the telemetry deserializer/register bank on tmdata.

Parameters:
- DATA_W, 32: data word width in bits (>=2).
- WORDS_PER_FRAME, 64: data words per frame after the sync word (>=1).
- SYNC_W, 32: sync word width in bits (>=2).
- SYNC_WORD, 32'h1ACFFC1D: sync pattern, always sent MSB first.
- LSB_FIRST, 0: 0 = data words MSB first; 1 = data words LSB first.
- FILL_WORD, 0: word substituted on underrun.
- IDLE_BIT, 1'b0: tm_data level between frames.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset, asynchronous, active-high; clock clk.
- bit_en, input, 1: single-cycle bit strobe; tm_data advances only on cycles with bit_en=1.
- s_data, input, DATA_W: parallel word in.
- s_valid, input, 1: s_data valid.
- s_ready, output, 1: holding buffer empty; equals ~hold_full (combinational from a register).
- tm_data, output, 1: serial output (registered).
- tm_fsync, output, 1: high for exactly the bit period of the first sync bit.
- tm_active, output, 1: high while a frame bit is being driven.
- tm_word_idx, output, clog2(WORDS_PER_FRAME+1): 0 during sync, k+1 during data word k.
- underrun, output, 1: one-clk pulse when FILL_WORD is substituted.
- underrun_cnt, output, 8: saturating count of underruns; cleared only by reset.

Behaviour:
- Reset values: tm_data=IDLE_BIT, tm_fsync=0, tm_active=0, tm_word_idx=0, underrun=0, underrun_cnt=0, hold empty (s_ready=1), state IDLE.
- Reset mid-frame aborts the frame immediately and discards any held word.
- Handshake:
  - Transfer occurs on a posedge clk with s_valid & s_ready, independent of bit_en.
  - The word is stored in hold; s_ready falls the next cycle.
  - hold is freed on the clk where it is loaded into the shifter; s_ready rises the following cycle.
  - A transfer and a load in the same clk cannot conflict, because s_ready=0 whenever hold is full.
- FSM states: IDLE, SYNC, DATA. All transitions and output updates happen only on bit_en cycles.
- IDLE:
  - tm_data=IDLE_BIT, tm_active=0.
  - On bit_en with hold_full=1: enter SYNC and drive tm_data=SYNC_WORD[SYNC_W-1] with tm_fsync=1, tm_active=1, tm_word_idx=0.
  - With hold empty: stay in IDLE. The sync word never consumes hold.
  - Latency: a word accepted at clk t starts a frame on the first bit_en at t+1 or later.
- SYNC:
  - Each bit_en drives the next sync bit; tm_fsync returns to 0 on the second bit_en.
  - On the bit_en after the last sync bit: enter DATA, word 0, tm_word_idx=1.
- DATA, word boundaries (the first bit of each word):
  - If hold_full: load hold into the shifter and free hold.
  - Else: load FILL_WORD, pulse underrun for 1 clk, and increment underrun_cnt (saturates at 255).
  - The first bit is driven on the same bit_en as the load: MSB when LSB_FIRST=0, bit 0 when LSB_FIRST=1.
  - Each of the following DATA_W-1 bit_en cycles drives the next bit.
- End of frame (bit_en after the last bit of word WORDS_PER_FRAME-1):
  - hold_full: go directly to SYNC with tm_fsync=1, giving back-to-back frames with zero gap bits.
  - Else: go to IDLE, tm_data=IDLE_BIT, tm_active=0, tm_word_idx=0.
- Counting: a bit counter of width clog2(max(DATA_W,SYNC_W)) and a word counter. Counters wrap to 0 at each boundary; no off-by-one.
- Frame length is exactly SYNC_W + WORDS_PER_FRAME*DATA_W bit_en cycles.
- bit_en held high every cycle gives one bit per clk. bit_en low freezes all serial state; the handshake stays live.

Test Plan (DATA_W=8, WORDS_PER_FRAME=4, SYNC_W=8, SYNC_WORD=8'hF9, FILL_WORD=8'h00, IDLE_BIT=0):
- Reset held 10 clks, then release with no input -> tm_data=0, tm_active=0, s_ready=1, underrun_cnt=0 indefinitely.
- bit_en=1 every clk; push A4, 2B, B1, 5C ahead of demand -> tm_data bit sequence 11111001 10100100 00101011 10110001 01011100, then IDLE. tm_fsync high only on the first bit. tm_word_idx goes 0,1,2,3,4, 8 bits each. underrun never pulses.
- Same stream, LSB_FIRST=1 -> sync unchanged (11111001); A4 sent as 00100101.
- Push only A4 and 2B, then stop -> words 2 and 3 are 00000000; underrun pulses twice; underrun_cnt=2; then IDLE.
- Keep hold continuously fed for 3 frames -> 3×40 contiguous bits; tm_fsync at bit 0, 40 and 80; tm_active never drops.
- bit_en every 4th clk; assert reset on the 13th bit of a frame -> outputs return to reset values asynchronously. After release and a new push, the frame restarts with sync F9 and no residue from the aborted frame.

Source files
------------

// File: rtl/tm_frame_serializer.sv
// Telemetry frame serializer: a sync word followed by WORDS_PER_FRAME data words on one serial line.
// Input words arrive through a one-word holding buffer; missing words are replaced by FILL_WORD.
module tm_frame_serializer #(
    parameter int                DATA_W          = 32,
    parameter int                WORDS_PER_FRAME = 64,
    parameter int                SYNC_W          = 32,
    parameter logic [SYNC_W-1:0] SYNC_WORD       = 32'h1ACFFC1D,
    parameter bit                LSB_FIRST       = 1'b0,
    parameter logic [DATA_W-1:0] FILL_WORD       = '0,
    parameter logic              IDLE_BIT        = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   bit_en,
    input  logic [DATA_W-1:0]                      s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic                                   tm_data,
    output logic                                   tm_fsync,
    output logic                                   tm_active,
    output logic [$clog2(WORDS_PER_FRAME+1)-1:0]   tm_word_idx,
    output logic                                   underrun,
    output logic [7:0]                             underrun_cnt
);

    localparam int MAX_W = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
    localparam int BIT_W = $clog2(MAX_W);
    localparam int IDX_W = $clog2(WORDS_PER_FRAME + 1);

    localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(SYNC_W - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORDS_PER_FRAME);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t              state;
    logic                hold_full;
    logic [DATA_W-1:0]   hold_data;
    logic [SYNC_W-1:0]   sync_sh;
    logic [DATA_W-1:0]   data_sh;
    logic [BIT_W-1:0]    bit_cnt;

    logic [DATA_W-1:0]   load_word;
    logic                load_bit;
    logic [DATA_W-1:0]   load_sh;
    logic                last_data_bit;
    logic                frame_start;
    logic                word_bound;

    assign s_ready = ~hold_full;

    // Word presented at a word boundary: the held word, or the fill pattern on underrun.
    assign load_word = hold_full ? hold_data : FILL_WORD;
    assign load_bit  = LSB_FIRST ? load_word[0] : load_word[DATA_W-1];
    assign load_sh   = LSB_FIRST ? (load_word >> 1) : (load_word << 1);

    assign last_data_bit = (state == DATA) && (bit_cnt == DATA_LAST);
    // Sync never consumes hold, but a frame only starts when a data word is already waiting.
    assign frame_start   = hold_full &&
                           ((state == IDLE) || (last_data_bit && (tm_word_idx == IDX_LAST)));
    assign word_bound    = ((state == SYNC) && (bit_cnt == SYNC_LAST)) ||
                           (last_data_bit && (tm_word_idx != IDX_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold_full    <= 1'b0;
            hold_data    <= '0;
            sync_sh      <= '0;
            data_sh      <= '0;
            bit_cnt      <= '0;
            tm_data      <= IDLE_BIT;
            tm_fsync     <= 1'b0;
            tm_active    <= 1'b0;
            tm_word_idx  <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            if (s_valid && s_ready) begin
                hold_full <= 1'b1;
                hold_data <= s_data;
            end
            if (bit_en) begin
                tm_fsync <= 1'b0;
                if (frame_start) begin
                    state       <= SYNC;
                    tm_data     <= SYNC_WORD[SYNC_W-1];
                    sync_sh     <= SYNC_WORD << 1;
                    tm_fsync    <= 1'b1;
                    tm_active   <= 1'b1;
                    tm_word_idx <= '0;
                    bit_cnt     <= '0;
                end else if (word_bound) begin
                    state       <= DATA;
                    tm_data     <= load_bit;
                    data_sh     <= load_sh;
                    bit_cnt     <= '0;
                    tm_word_idx <= (state == SYNC) ? IDX_W'(1) : tm_word_idx + 1'b1;
                    if (hold_full) begin
                        hold_full <= 1'b0;
                    end else begin
                        underrun <= 1'b1;
                        if (underrun_cnt != 8'hFF)
                            underrun_cnt <= underrun_cnt + 8'd1;
                    end
                end else if (state == SYNC) begin
                    tm_data <= sync_sh[SYNC_W-1];
                    sync_sh <= sync_sh << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end else if ((state == DATA) && !last_data_bit) begin
                    tm_data <= LSB_FIRST ? data_sh[0] : data_sh[DATA_W-1];
                    data_sh <= LSB_FIRST ? (data_sh >> 1) : (data_sh << 1);
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    // Idle with nothing waiting, or end of frame with hold empty.
                    state       <= IDLE;
                    tm_data     <= IDLE_BIT;
                    tm_active   <= 1'b0;
                    tm_word_idx <= '0;
                    bit_cnt     <= '0;
                end
            end
        end
    end

endmodule
